// File: rtl/palette_encoder.sv
// Nearest-colour search over a fixed 16-entry 12-bit RGB palette.
// One palette entry is scored per cycle, and the search stops early when an exact match is found.
module palette_encoder (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       in_valid,
    input  logic [3:0] in_red,
    input  logic [3:0] in_green,
    input  logic [3:0] in_blue,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_index,
    output logic [5:0] out_dist,
    output logic       out_exact
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [11:0] rgb_q;
    logic [3:0]  i;
    logic        issue_done;
    logic        cand_vld;
    logic [5:0]  cand_dist;
    logic [3:0]  cand_idx;
    logic [5:0]  best_dist;
    logic [3:0]  best_idx;
    logic [5:0]  entry_dist;
    logic        better;
    logic        exit_now;

    function automatic logic [11:0] palette(input logic [3:0] idx);
        logic [11:0] c;
        case (idx)
            4'd0:    c = 12'h110;
            4'd1:    c = 12'h662;
            4'd2:    c = 12'h5BE;
            4'd3:    c = 12'hA82;
            4'd4:    c = 12'h112;
            4'd5:    c = 12'h134;
            4'd6:    c = 12'h000;
            4'd7:    c = 12'h432;
            4'd8:    c = 12'hD10;
            4'd9:    c = 12'hEA1;
            4'd10:   c = 12'h221;
            4'd11:   c = 12'h48B;
            4'd12:   c = 12'h521;
            4'd13:   c = 12'h161;
            4'd14:   c = 12'h111;
            default: c = 12'h357;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [5:0] manhattan(input logic [11:0] a, input logic [11:0] b);
        return {2'b00, abs_diff(a[11:8], b[11:8])}
             + {2'b00, abs_diff(a[7:4],  b[7:4])}
             + {2'b00, abs_diff(a[3:0],  b[3:0])};
    endfunction

    // Scoring is pipelined: entry i is scored into cand_* and compared against the best one cycle later.
    always_comb begin
        entry_dist = manhattan(rgb_q, palette(i));
        better     = cand_vld && (cand_dist < best_dist);
        exit_now   = cand_vld && ((cand_dist == 6'd0) || (cand_idx == 4'd15));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = SEARCH;
            SEARCH:  if (exit_now)  next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rgb_q      <= 12'h000;
            i          <= 4'd0;
            issue_done <= 1'b0;
            cand_vld   <= 1'b0;
            cand_dist  <= 6'd0;
            cand_idx   <= 4'd0;
            best_dist  <= 6'd0;
            best_idx   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rgb_q      <= {in_red, in_green, in_blue};
                        i          <= 4'd0;
                        issue_done <= 1'b0;
                        cand_vld   <= 1'b0;
                        best_dist  <= 6'd63;
                        best_idx   <= 4'd0;
                    end
                end
                SEARCH: begin
                    cand_vld  <= !issue_done && !exit_now;
                    cand_dist <= entry_dist;
                    cand_idx  <= i;
                    // The counter parks on 15 instead of wrapping once the last entry has been issued.
                    if (!issue_done) begin
                        if (i == 4'd15) begin
                            issue_done <= 1'b1;
                        end else begin
                            i <= i + 4'd1;
                        end
                    end
                    if (better) begin
                        best_dist <= cand_dist;
                        best_idx  <= cand_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        out_index = best_idx;
        out_dist  = best_dist;
        out_exact = (state == DONE) && (best_dist == 6'd0);
    end

endmodule

// File: tb/tb_palette_encoder.sv
// Directed-vector bench for palette_encoder: nearest index, distance, exact flag, latency,
// back-pressure stability, handshake isolation and reset abort.
module tb_palette_encoder;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       in_valid;
    logic [3:0] in_red;
    logic [3:0] in_green;
    logic [3:0] in_blue;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_index;
    logic [5:0] out_dist;
    logic       out_exact;

    int checks   = 0;
    int failures = 0;

    palette_encoder dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_red    (in_red),
        .in_green  (in_green),
        .in_blue   (in_blue),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_dist  (out_dist),
        .out_exact (out_exact)
    );

    // Free-running clock, 10 time units per period.
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Sends one request, measures latency from the accepting edge, checks the result,
    // optionally holds out_ready low, then completes the handshake.
    // With noisy set, in_valid and the colour inputs churn while the encoder is busy.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                                 input logic [3:0] exp_idx, input logic [5:0] exp_dist,
                                 input logic exp_exact, input int exp_lat,
                                 input int hold, input bit noisy);
        int  lat;
        bit  busy_err;
        for (int n = 0; n < 50 && !in_ready; n++) begin
            @(posedge Clk);
            #1;
        end
        checkOutput("ready_before", int'(in_ready), 1);
        in_red   = r;
        in_green = g;
        in_blue  = b;
        in_valid = 1'b1;
        @(posedge Clk);
        #1;
        if (!noisy) in_valid = 1'b0;
        lat      = 41;
        busy_err = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge Clk);
            #1;
            if (noisy) begin
                in_red   = 4'($urandom);
                in_green = 4'($urandom);
                in_blue  = 4'($urandom);
            end
            if (out_valid) begin
                lat = n;
                break;
            end
            if (in_ready) busy_err = 1'b1;
        end
        checkOutput("latency", lat, exp_lat);
        checkOutput("busy_ready", int'(busy_err), 0);
        checkOutput("index", int'(out_index), int'(exp_idx));
        checkOutput("dist", int'(out_dist), int'(exp_dist));
        checkOutput("exact", int'(out_exact), int'(exp_exact));
        for (int k = 0; k < hold; k++) begin
            @(posedge Clk);
            #1;
            checkOutput("hold", int'({out_valid, in_ready, out_index, out_dist, out_exact}),
                        int'({1'b1, 1'b0, exp_idx, exp_dist, exp_exact}));
        end
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        checkOutput("release", int'({in_ready, out_valid}), int'({1'b1, 1'b0}));
        in_valid = 1'b0;
    endtask

    // Main sequence: reset, directed vectors, reset abort, recovery request.
    initial begin
        bit saw_valid;
        Reset     = 1'b1;
        in_valid  = 1'b0;
        in_red    = 4'h0;
        in_green  = 4'h0;
        in_blue   = 4'h0;
        out_ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        checkOutput("rst_ready", int'(in_ready), 1);
        checkOutput("rst_valid", int'(out_valid), 0);
        checkOutput("rst_index", int'(out_index), 0);
        checkOutput("rst_dist", int'(out_dist), 0);
        checkOutput("rst_exact", int'(out_exact), 0);

        applyStimulus(4'h0, 4'h0, 4'h0, 4'd6,  6'd0,  1'b1, 8,  0,  1'b0);
        applyStimulus(4'h1, 4'h1, 4'h1, 4'd14, 6'd0,  1'b1, 16, 0,  1'b0);
        applyStimulus(4'hF, 4'hF, 4'hF, 4'd2,  6'd15, 1'b0, 17, 10, 1'b0);
        applyStimulus(4'h0, 4'h1, 4'h0, 4'd0,  6'd1,  1'b0, 17, 0,  1'b0);
        applyStimulus(4'h7, 4'h7, 4'h7, 4'd15, 6'd6,  1'b0, 17, 2,  1'b1);
        applyStimulus(4'hD, 4'h1, 4'h0, 4'd8,  6'd0,  1'b1, 10, 0,  1'b1);

        in_red   = 4'hF;
        in_green = 4'hF;
        in_blue  = 4'hF;
        in_valid = 1'b1;
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        Reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        Reset     = 1'b0;
        out_ready = 1'b0;
        checkOutput("abort_ready", int'(in_ready), 1);
        checkOutput("abort_valid", int'(out_valid), 0);
        saw_valid = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(posedge Clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("abort_no_result", int'(saw_valid), 0);

        applyStimulus(4'h0, 4'h0, 4'h0, 4'd6, 6'd0, 1'b1, 8, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so a wedged design cannot hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/palette_encoder.md
PALETTE_ENCODER -- requirements
Module: palette_encoder

Interface
REQ-001 SHALL expose: Clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL expose: Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL expose: in_valid  input  1  RGB request present.
REQ-004 SHALL expose: in_red, in_green, in_blue  input  4 each  requested 12-bit colour.
REQ-005 SHALL expose: in_ready  output  1  encoder can accept a request.
REQ-006 SHALL expose: out_valid  output  1  result present.
REQ-007 SHALL expose: out_ready  input  1  consumer takes the result.
REQ-008 SHALL expose: out_index  output  4  nearest palette index.
REQ-009 SHALL expose: out_dist  output  6  distance of chosen entry, range 0..45.
REQ-010 SHALL expose: out_exact  output  1  high when out_dist == 0.
REQ-011 The design SHALL use one clock (Clk) with synchronous, active-high Reset; no other clock or asynchronous reset.

Function
REQ-012 SHALL hold a fixed 16-entry table {R,G,B}: 0 {1,1,0}, 1 {6,6,2}, 2 {5,B,E}, 3 {A,8,2}, 4 {1,1,2}, 5 {1,3,4}, 6 {0,0,0}, 7 {4,3,2}.
REQ-013 Table continued: 8 {D,1,0}, 9 {E,A,1}, 10 {2,2,1}, 11 {4,8,B}, 12 {5,2,1}, 13 {1,6,1}, 14 {1,1,1}, 15 {3,5,7}. Values hex.
REQ-014 Distance SHALL be |dR|+|dG|+|dB|, each term computed unsigned on 4 bits, summed in 6 bits, no overflow.
REQ-015 FSM states SHALL be IDLE, SEARCH, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 IDLE: on in_valid && in_ready, latch RGB, set best_dist = 63, best_idx = 0, entry counter i = 0, go to SEARCH.
REQ-017 SEARCH: one entry per cycle, i = 0..15 ascending; if dist(i) < best_dist (strict), update best_dist and best_idx.
REQ-018 Ties SHALL resolve to the lowest index; strict compare guarantees this.
REQ-019 SEARCH SHALL exit to DONE after entry 15 or in the cycle an entry with dist == 0 is found (early exit).
REQ-020 Latency: request accepted at edge T, entry i evaluated in cycle T+1+i; out_valid asserted from T+17 (no exact match) or T+k+2 (exact at entry k).
REQ-021 DONE: out_index, out_dist, out_exact SHALL stay stable while out_valid && !out_ready; state returns to IDLE on the edge where out_ready is high.
REQ-022 A new request SHALL NOT be accepted in the same cycle as a result handshake; in_valid is ignored outside IDLE.
REQ-023 Latched RGB SHALL NOT change during SEARCH/DONE regardless of input activity.
REQ-024 Counter i SHALL not wrap: after evaluating 15 the FSM leaves SEARCH.

Reset
REQ-025 On Reset: state = IDLE, in_ready = 1, out_valid = 0, out_index = 0, out_dist = 0, out_exact = 0, i = 0.
REQ-026 Reset asserted in SEARCH or DONE SHALL abort the operation; no out_valid for the aborted request.
REQ-027 Reset SHALL take priority over every handshake in the same cycle.

Verification
REQ-028 Exact early: {0,0,0} accepted at T, out_ready = 1 -> out_valid at T+8, out_index 6, out_dist 0, out_exact 1.
REQ-029 Exact late: {1,1,1} -> out_valid at T+16, index 14, dist 0, exact 1; entry 0 (dist 1) must not win.
REQ-030 Full search: {F,F,F} -> out_valid at T+17, index 2, dist 15, exact 0.
REQ-031 Tie: {0,1,0} -> entries 0 and 6 both dist 1; out_index 0, dist 1, exact 0, out_valid at T+17.
REQ-032 Back-pressure: {F,F,F} with out_ready held low 10 cycles -> outputs stable and in_ready low throughout; IDLE one cycle after out_ready rises.
REQ-033 Reset mid-search: Reset at T+5 -> next cycle in_ready 1, out_valid 0; following request {0,0,0} completes normally at index 6.
